// File: rtl/sample_scheduler.sv
// Round-robin sampling engine on the EBI register bus: scans a programmable slot
// list over the shared sample bus and queues captured words in a FIFO for the MCU.
module sample_scheduler #(
  parameter int POSITION   = 300,
  parameter int NUM_SLOTS  = 8,
  parameter int FIFO_DEPTH = 256,
  parameter int DIV_RESET  = 75
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [18:0] addr,
  input  logic        data_wr,
  input  logic [15:0] data_in,
  input  logic        data_rd,
  output logic [15:0] data_out,
  output logic        output_sample,
  output logic [7:0]  channel_select,
  input  logic [15:0] sample_data
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [18:0] BASE    = 19'(POSITION);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SELECT,
    S_CAPTURE,
    S_WAIT
  } state_t;

  // Register file
  logic        run_q, run_d;
  logic        ovwr_q, ovwr_d;
  logic [15:0] div_q, div_d;
  logic [15:0] nact_q, nact_d;
  logic [7:0]  slot_q [NUM_SLOTS];
  logic [7:0]  slot_d [NUM_SLOTS];
  logic        ovf_q, ovf_d;
  logic        udf_q, udf_d;
  logic [7:0]  last_chan_q, last_chan_d;

  // Bus strobe edge detection
  logic        wr_prev_q, wr_prev_d;
  logic        rd_prev_q, rd_prev_d;

  // Scan engine
  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  chan_q, chan_d;
  logic [15:0] per_q, per_d;
  logic [15:0] wait_q, wait_d;

  // FIFO
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [23:0]   fifo_mem [FIFO_DEPTH];
  logic [23:0]   head;
  logic          mem_we;

  logic        in_win;
  logic [4:0]  off;
  logic        wr_sel, wr_fire, rd_data_sel, pop_req;
  logic        clear;
  logic        push;
  logic        fifo_empty, fifo_full;
  logic [15:0] div_eff;
  logic [4:0]  na_eff;
  logic [3:0]  nidx;
  logic [7:0]  nxt_slot;

  assign in_win      = (addr >= BASE) && (addr < BASE + 19'd32);
  assign off         = 5'(addr - BASE);
  assign wr_sel      = enable & data_wr & in_win;
  assign wr_fire     = wr_sel & ~wr_prev_q;
  assign rd_data_sel = enable & data_rd & in_win & (off == 5'd5);
  // The pop lands after the strobe drops so data_out holds still while it is high.
  assign pop_req     = rd_prev_q & ~rd_data_sel;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == DEPTH_C);
  assign head       = fifo_mem[rd_ptr_q];

  assign div_eff = (div_q < 16'd2) ? 16'd2 : div_q;

  always_comb begin
    na_eff = 5'(nact_q);
    if (nact_q == 16'd0) begin
      na_eff = 5'd1;
    end else if (nact_q > 16'(NUM_SLOTS)) begin
      na_eff = 5'(NUM_SLOTS);
    end
  end

  always_comb begin
    nidx = idx_q + 4'd1;
    if (({1'b0, idx_q} + 5'd1) >= na_eff) begin
      nidx = 4'd0;
    end
    nxt_slot = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (nidx == 4'(k)) begin
        nxt_slot = slot_q[k];
      end
    end
  end

  always_comb begin
    run_d  = run_q;
    ovwr_d = ovwr_q;
    div_d  = div_q;
    nact_d = nact_q;
    slot_d = slot_q;
    clear  = 1'b0;
    if (wr_fire) begin
      case (off)
        5'd0: begin
          run_d  = data_in[0];
          clear  = data_in[1];
          ovwr_d = data_in[2];
        end
        5'd1: div_d  = data_in;
        5'd2: nact_d = data_in;
        default: begin
          for (int k = 0; k < NUM_SLOTS; k++) begin
            if (off == 5'(16 + k)) begin
              slot_d[k] = data_in[7:0];
            end
          end
        end
      endcase
    end
    wr_prev_d = wr_sel;
    rd_prev_d = rd_data_sel;
  end

  // Scan FSM: period and channel are latched on entry to SELECT, so config
  // writes made mid-slot only apply from the following slot.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    chan_d  = chan_q;
    per_d   = per_q;
    wait_d  = wait_q;
    push    = 1'b0;
    if (!run_q) begin
      state_d = S_IDLE;
      idx_d   = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_SELECT;
          idx_d   = 4'd0;
          chan_d  = slot_q[0];
          per_d   = div_eff;
        end
        S_SELECT: state_d = S_CAPTURE;
        S_CAPTURE: begin
          push = 1'b1;
          if (per_q <= 16'd2) begin
            state_d = S_SELECT;
            idx_d   = nidx;
            chan_d  = nxt_slot;
            per_d   = div_eff;
          end else begin
            state_d = S_WAIT;
            wait_d  = per_q - 16'd2;
          end
        end
        S_WAIT: begin
          if (wait_q <= 16'd1) begin
            state_d = S_SELECT;
            idx_d   = nidx;
            chan_d  = nxt_slot;
            per_d   = div_eff;
          end else begin
            wait_d = wait_q - 16'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign output_sample  = run_q & ((state_q == S_SELECT) | (state_q == S_CAPTURE));
  assign channel_select = output_sample ? chan_q : 8'd0;

  // FIFO bookkeeping; CLEAR overrides any push or pop in the same cycle.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    udf_d       = udf_q;
    last_chan_d = last_chan_q;
    mem_we      = 1'b0;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (pop_req && fifo_empty) begin
        udf_d = 1'b1;
      end
      if (push) begin
        if (pop_req && !fifo_empty) begin
          mem_we      = 1'b1;
          wr_ptr_d    = wr_ptr_q + 1'b1;
          rd_ptr_d    = rd_ptr_q + 1'b1;
          last_chan_d = head[23:16];
        end else if (!fifo_full) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          cnt_d    = cnt_q + 1'b1;
        end else if (ovwr_q) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          rd_ptr_d = rd_ptr_q + 1'b1;
          ovf_d    = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end else if (pop_req && !fifo_empty) begin
        rd_ptr_d    = rd_ptr_q + 1'b1;
        cnt_d       = cnt_q - 1'b1;
        last_chan_d = head[23:16];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      fifo_mem[wr_ptr_q] <= {chan_q, sample_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      run_q       <= 1'b0;
      ovwr_q      <= 1'b0;
      div_q       <= 16'(DIV_RESET);
      nact_q      <= 16'(NUM_SLOTS);
      for (int k = 0; k < NUM_SLOTS; k++) begin
        slot_q[k] <= 8'(k);
      end
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
      last_chan_q <= 8'd0;
      wr_prev_q   <= 1'b0;
      rd_prev_q   <= 1'b0;
      state_q     <= S_IDLE;
      idx_q       <= 4'd0;
      chan_q      <= 8'd0;
      per_q       <= 16'd2;
      wait_q      <= 16'd0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
    end else begin
      run_q       <= run_d;
      ovwr_q      <= ovwr_d;
      div_q       <= div_d;
      nact_q      <= nact_d;
      slot_q      <= slot_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
      last_chan_q <= last_chan_d;
      wr_prev_q   <= wr_prev_d;
      rd_prev_q   <= rd_prev_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      chan_q      <= chan_d;
      per_q       <= per_d;
      wait_q      <= wait_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    data_out = 16'd0;
    if (enable && data_rd && in_win) begin
      case (off)
        5'd0: data_out = {13'd0, ovwr_q, 1'b0, run_q};
        5'd1: data_out = div_q;
        5'd2: data_out = nact_q;
        5'd3: data_out = {12'd0, udf_q, ovf_q, fifo_full, fifo_empty};
        5'd4: data_out = 16'(cnt_q);
        5'd5: data_out = fifo_empty ? 16'd0 : head[15:0];
        5'd6: data_out = {8'd0, last_chan_q};
        default: begin
          for (int k = 0; k < NUM_SLOTS; k++) begin
            if (off == 5'(16 + k)) begin
              data_out = {8'd0, slot_q[k]};
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sample_scheduler.sv
// Bench for sample_scheduler: scenario tasks with randomized slot tables checked
// against a queue-based model of the scan order and FIFO drop policy.
module tb_sample_scheduler;

  localparam int BASE  = 300;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [18:0] addr = '0;
  logic        data_wr = 1'b0;
  logic [15:0] data_in = '0;
  logic        data_rd = 1'b0;
  logic [15:0] data_out;
  logic        output_sample;
  logic [7:0]  channel_select;
  logic [15:0] sample_data;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Channel owners answer with 0x1000 + id while sampled.
  assign sample_data = output_sample ? (16'h1000 + {8'h00, channel_select}) : 16'h0000;

  sample_scheduler #(
    .POSITION  (BASE),
    .NUM_SLOTS (8),
    .FIFO_DEPTH(DEPTH),
    .DIV_RESET (75)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .addr          (addr),
    .data_wr       (data_wr),
    .data_in       (data_in),
    .data_rd       (data_rd),
    .data_out      (data_out),
    .output_sample (output_sample),
    .channel_select(channel_select),
    .sample_data   (sample_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic reg_write_now(input int off, input logic [15:0] v);
    enable  = 1'b1;
    data_wr = 1'b1;
    addr    = 19'(BASE + off);
    data_in = v;
    @(negedge clk);
    enable  = 1'b0;
    data_wr = 1'b0;
    data_in = '0;
  endtask

  task automatic reg_write(input int off, input logic [15:0] v);
    @(negedge clk);
    reg_write_now(off, v);
  endtask

  task automatic reg_read(input int off, output logic [15:0] v);
    @(negedge clk);
    enable  = 1'b1;
    data_rd = 1'b1;
    addr    = 19'(BASE + off);
    #1 v = data_out;
    @(negedge clk);
    enable  = 1'b0;
    data_rd = 1'b0;
  endtask

  task automatic wait_rise(output bit ok);
    logic prev;
    prev = output_sample;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (output_sample && !prev) begin
        ok = 1'b1;
        break;
      end
      prev = output_sample;
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_rise: no output_sample rise in 400 cycles, required a rise");
    end
  endtask

  function automatic int clamp_na(input int raw);
    if (raw == 0) return 1;
    if (raw > 8) return 8;
    return raw;
  endfunction

  task automatic test_reset();
    logic [15:0] v;
    logic [15:0] exp_rst [7];
    bit bad;
    exp_rst = '{16'd0, 16'd75, 16'd8, 16'h1, 16'd0, 16'd0, 16'd0};
    reset = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if ({output_sample, channel_select, data_out} !== 25'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %0h/%0h/%0h required 0/0/0", output_sample, channel_select, data_out);
    end
    reset = 1'b1;
    for (int o = 0; o < 7; o++) begin
      reg_read(o, v);
      n_cmp++;
      if (v !== exp_rst[o]) begin
        n_fail++;
        $display("FAIL reset_reg%0d: got 0x%0h required 0x%0h", o, v, exp_rst[o]);
      end
    end
    for (int k = 0; k < 8; k++) begin
      reg_read(16 + k, v);
      n_cmp++;
      if (v !== 16'(k)) begin
        n_fail++;
        $display("FAIL reset_slot%0d: got 0x%0h required 0x%0h", k, v, k);
      end
    end
    foreach (exp_rst[i]) exp_rst[i] = 16'd0;
    for (int j = 0; j < 3; j++) begin
      int o;
      o = (j == 0) ? 7 : (j == 1) ? 24 : 31;
      reg_read(o, v);
      n_cmp++;
      if (v !== 16'd0) begin
        n_fail++;
        $display("FAIL unmapped_off%0d: got 0x%0h required 0x0", o, v);
      end
    end
    @(negedge clk);
    enable = 1'b1; data_rd = 1'b1; addr = 19'(BASE - 1);
    #1;
    n_cmp++;
    if (data_out !== 16'd0) begin
      n_fail++;
      $display("FAIL outside_window: got 0x%0h required 0x0", data_out);
    end
    @(negedge clk);
    enable = 1'b0; data_rd = 1'b0;
    bad = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (output_sample !== 1'b0) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_fail++;
      $display("FAIL reset_idle: output_sample got 1 during 100 idle cycles, required 0");
    end
  endtask

  // Programs a scan, checks channel order and spacing over four slots, aborts
  // at the fourth SELECT so exactly three words are queued, then drains them.
  task automatic run_scan(input logic [7:0] s [8], input int na_raw, input int div_raw, input string tag);
    logic [15:0] v;
    bit ok;
    int na, per, last_cyc;
    logic [7:0] exp_ch;
    na  = clamp_na(na_raw);
    per = (div_raw < 2) ? 2 : div_raw;
    reg_write(0, 16'h2);
    for (int k = 0; k < 8; k++) reg_write(16 + k, {8'd0, s[k]});
    reg_write(2, 16'(na_raw));
    reg_write(1, 16'(div_raw));
    reg_write(0, 16'h3);
    last_cyc = 0;
    for (int k = 0; k < 4; k++) begin
      wait_rise(ok);
      if (!ok) break;
      exp_ch = s[k % na];
      n_cmp++;
      if (channel_select !== exp_ch) begin
        n_fail++;
        $display("FAIL %s_chan%0d: got %0d required %0d", tag, k, channel_select, exp_ch);
      end
      if (k > 0) begin
        n_cmp++;
        if (cyc - last_cyc != per) begin
          n_fail++;
          $display("FAIL %s_period%0d: got %0d required %0d", tag, k, cyc - last_cyc, per);
        end
      end
      last_cyc = cyc;
      if (k < 3) begin
        @(negedge clk);
        n_cmp++;
        if (output_sample !== 1'b1) begin
          n_fail++;
          $display("FAIL %s_high2_%0d: got %0b required 1", tag, k, output_sample);
        end
        @(negedge clk);
        n_cmp++;
        if (output_sample !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_low3_%0d: got %0b required 0", tag, k, output_sample);
        end
      end else begin
        reg_write_now(0, 16'h0);
      end
    end
    reg_read(4, v);
    n_cmp++;
    if (v !== 16'd3) begin
      n_fail++;
      $display("FAIL %s_count: got %0d required 3", tag, v);
    end
    for (int k = 0; k < 3; k++) begin
      reg_read(5, v);
      n_cmp++;
      if (v !== 16'h1000 + {8'd0, s[k % na]}) begin
        n_fail++;
        $display("FAIL %s_pop%0d: got 0x%0h required 0x%0h", tag, k, v, 16'h1000 + {8'd0, s[k % na]});
      end
    end
    reg_read(6, v);
    n_cmp++;
    if (v !== {8'd0, s[2 % na]}) begin
      n_fail++;
      $display("FAIL %s_last_chan: got %0d required %0d", tag, v, s[2 % na]);
    end
  endtask

  task automatic test_scan();
    logic [7:0] s [8];
    s = '{8'd100, 8'd101, 8'd3, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    run_scan(s, 3, 10, "scan");
  endtask

  task automatic test_random_scan();
    logic [7:0] s [8];
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 8; k++) s[k] = 8'($urandom_range(0, 255));
      run_scan(s, int'($urandom_range(0, 10)), int'($urandom_range(3, 12)), "rscan");
    end
  endtask

  task automatic test_overflow(input bit ovwr);
    logic [7:0] s [8];
    logic [7:0] q [$];
    logic [15:0] v;
    logic [7:0] ch;
    bit ok;
    int na_raw, na;
    for (int k = 0; k < 8; k++) s[k] = 8'($urandom_range(0, 255));
    na_raw = int'($urandom_range(0, 10));
    na = clamp_na(na_raw);
    reg_write(0, 16'h2);
    for (int k = 0; k < 8; k++) reg_write(16 + k, {8'd0, s[k]});
    reg_write(2, 16'(na_raw));
    reg_write(1, 16'd8);
    reg_write(0, {13'd0, ovwr, 2'b11});
    for (int k = 0; k < 7; k++) begin
      wait_rise(ok);
      if (!ok) break;
      if (k == 6) reg_write_now(0, {13'd0, ovwr, 2'b00});
    end
    for (int k = 0; k < 6; k++) begin
      if (q.size() < DEPTH) q.push_back(s[k % na]);
      else if (ovwr) begin
        void'(q.pop_front());
        q.push_back(s[k % na]);
      end
    end
    reg_read(4, v);
    n_cmp++;
    if (v !== 16'(q.size())) begin
      n_fail++;
      $display("FAIL ovf%0b_count: got %0d required %0d", ovwr, v, q.size());
    end
    reg_read(3, v);
    n_cmp++;
    if (v !== 16'h6) begin
      n_fail++;
      $display("FAIL ovf%0b_status: got 0x%0h required 0x6", ovwr, v);
    end
    while (q.size() > 0) begin
      ch = q.pop_front();
      reg_read(5, v);
      n_cmp++;
      if (v !== 16'h1000 + {8'd0, ch}) begin
        n_fail++;
        $display("FAIL ovf%0b_pop: got 0x%0h required 0x%0h", ovwr, v, 16'h1000 + {8'd0, ch});
      end
    end
    reg_read(3, v);
    n_cmp++;
    if (v !== 16'h5) begin
      n_fail++;
      $display("FAIL ovf%0b_status_drained: got 0x%0h required 0x5", ovwr, v);
    end
  endtask

  task automatic test_underflow();
    logic [15:0] v;
    reg_write(0, 16'h2);
    reg_read(5, v);
    n_cmp++;
    if (v !== 16'd0) begin
      n_fail++;
      $display("FAIL udf_data: got 0x%0h required 0x0", v);
    end
    reg_read(3, v);
    n_cmp++;
    if (v !== 16'h9) begin
      n_fail++;
      $display("FAIL udf_status: got 0x%0h required 0x9", v);
    end
    reg_read(4, v);
    n_cmp++;
    if (v !== 16'd0) begin
      n_fail++;
      $display("FAIL udf_count: got %0d required 0", v);
    end
    reg_write(0, 16'h2);
    reg_read(3, v);
    n_cmp++;
    if (v !== 16'h1) begin
      n_fail++;
      $display("FAIL clear_status: got 0x%0h required 0x1", v);
    end
  endtask

  task automatic test_abort();
    logic [7:0] s [8];
    logic [15:0] v;
    bit ok;
    for (int k = 0; k < 8; k++) s[k] = 8'($urandom_range(0, 255));
    reg_write(0, 16'h2);
    for (int k = 0; k < 3; k++) reg_write(16 + k, {8'd0, s[k]});
    reg_write(2, 16'd3);
    reg_write(1, 16'd6);
    reg_write(0, 16'h3);
    for (int k = 0; k < 3; k++) begin
      wait_rise(ok);
      if (!ok) break;
    end
    reg_write_now(0, 16'h0);
    n_cmp++;
    if ({output_sample, channel_select} !== 9'd0) begin
      n_fail++;
      $display("FAIL abort_outputs: got %0b/%0d required 0/0", output_sample, channel_select);
    end
    repeat (10) @(negedge clk);
    reg_read(4, v);
    n_cmp++;
    if (v !== 16'd2) begin
      n_fail++;
      $display("FAIL abort_count: got %0d required 2", v);
    end
    for (int k = 0; k < 2; k++) begin
      reg_read(5, v);
      n_cmp++;
      if (v !== 16'h1000 + {8'd0, s[k]}) begin
        n_fail++;
        $display("FAIL abort_pop%0d: got 0x%0h required 0x%0h", k, v, 16'h1000 + {8'd0, s[k]});
      end
    end
    reg_write(0, 16'h1);
    wait_rise(ok);
    n_cmp++;
    if (channel_select !== s[0]) begin
      n_fail++;
      $display("FAIL rearm_chan: got %0d required %0d", channel_select, s[0]);
    end
    reg_write(0, 16'h2);
  endtask

  task automatic test_div0_hold_read();
    logic [7:0] s0;
    logic [15:0] v, first;
    bit ok, bad;
    int exp_cnt;
    s0 = 8'($urandom_range(0, 255));
    reg_write(0, 16'h2);
    reg_write(16, {8'd0, s0});
    reg_write(1, 16'd0);
    reg_write(2, 16'd0);
    reg_write(0, 16'h3);
    enable = 1'b1; data_rd = 1'b1; addr = 19'(BASE + 4);
    wait_rise(ok);
    for (int k = 0; k < 10; k++) begin
      exp_cnt = (k / 2 > DEPTH) ? DEPTH : k / 2;
      n_cmp++;
      if ({output_sample, channel_select, data_out} !== {1'b1, s0, 16'(exp_cnt)}) begin
        n_fail++;
        $display("FAIL div0_cycle%0d: got os=%0b ch=%0d cnt=%0d required os=1 ch=%0d cnt=%0d",
                 k, output_sample, channel_select, data_out, s0, exp_cnt);
      end
      @(negedge clk);
    end
    enable = 1'b0; data_rd = 1'b0;
    reg_write(0, 16'h0);
    reg_read(4, v);
    n_cmp++;
    if (v !== 16'(DEPTH)) begin
      n_fail++;
      $display("FAIL div0_full: got %0d required %0d", v, DEPTH);
    end
    @(negedge clk);
    enable = 1'b1; data_rd = 1'b1; addr = 19'(BASE + 5);
    #1 first = data_out;
    n_cmp++;
    if (first !== 16'h1000 + {8'd0, s0}) begin
      n_fail++;
      $display("FAIL hold_data: got 0x%0h required 0x%0h", first, 16'h1000 + {8'd0, s0});
    end
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (data_out !== first) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_fail++;
      $display("FAIL hold_stable: data_out changed while strobe high, required 0x%0h", first);
    end
    enable = 1'b0; data_rd = 1'b0;
    reg_read(4, v);
    n_cmp++;
    if (v !== 16'(DEPTH - 1)) begin
      n_fail++;
      $display("FAIL hold_one_pop: got %0d required %0d", v, DEPTH - 1);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_random_scan();
    test_overflow(1'b0);
    test_overflow(1'b1);
    test_underflow();
    test_abort();
    test_div0_hold_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench still running at 2 ms, required completion");
    $fatal(1);
  end

endmodule

// File: doc/sample_scheduler.md
# sample_scheduler

Parametrised sampling engine on the EBI register bus. It scans a programmable list of sample channels round-robin over the shared sample bus (output_sample / channel_select / sample_data) at a programmable rate. Each captured word goes into an internal FIFO that the MCU drains through EBI reads. It sits beside the pin, ADC and DAC controllers, decodes its own address window, and drives the wired-OR data_out bus.

## Interface
- POSITION, 300: base EBI word address of the register window.
- NUM_SLOTS, 8: scan-list length (1..16).
- FIFO_DEPTH, 256: FIFO words; power of two, 4..1024.
- DIV_RESET, 75: reset value of DIVIDER (1 MHz slot rate at 75 MHz).

Ports:
- clk  in  1  system clock (sys_clk domain).
- reset  in  1  synchronous, active-low; reset==0 at a clk rising edge resets all state.
- enable  in  1  EBI chip select, active-high.
- addr  in  19  EBI word address.
- data_wr  in  1  write strobe, active-high.
- data_in  in  16  write data.
- data_rd  in  1  read strobe, active-high.
- data_out  out  16  read data; 0 when not addressed (wired-OR bus).
- output_sample  out  1  sample request to channel owners.
- channel_select  out  8  channel id being sampled.
- sample_data  in  16  wired-OR sample bus from the channel owners.

## Operation
Register map (offset from POSITION):
- 0 CTRL (rw): bit0 RUN; bit1 CLEAR (write 1 to flush FIFO and clear sticky bits, self-clearing, reads 0); bit2 OVWR (1 = drop oldest when full, 0 = drop newest).
- 1 DIVIDER (rw): clk cycles per slot. Values below 2 are treated as 2.
- 2 NUM_ACTIVE (rw): slots in use. 0 is treated as 1; values above NUM_SLOTS are clamped to NUM_SLOTS.
- 3 STATUS (ro): bit0 EMPTY, bit1 FULL, bit2 OVERFLOW (sticky), bit3 UNDERFLOW (sticky).
- 4 COUNT (ro): FIFO fill level, 0..FIFO_DEPTH.
- 5 DATA (ro): FIFO head, first-word-fall-through; reads 0 when empty.
- 6 LAST_CHAN (ro): channel id of the word most recently popped.
- 16+k SLOT[k] (rw, [7:0]): channel id for slot k. Reset value k.

EBI access:
- A write commits once, on the rising edge of (enable & data_wr & addr in window).
- A DATA read pops on the falling edge of the qualified read strobe. data_out stays stable while the strobe is high; one pop per strobe.
- Reads of unmapped offsets inside the window return 0.

Scan FSM:
- States: IDLE, SELECT, CAPTURE, WAIT.
- IDLE -> SELECT when RUN=1; slot index starts at 0.
- SELECT: output_sample=1, channel_select=SLOT[idx].
- CAPTURE: outputs held; at the end of this cycle, sample_data is pushed along with its channel id.
- WAIT: outputs 0; counts DIVIDER-2 cycles, then advances idx modulo NUM_ACTIVE and goes to SELECT.
- RUN=0 in any state: IDLE on the next edge, outputs 0, idx=0, no push from an aborted slot.
- Config writes while running take effect at the next SELECT.

FIFO boundaries:
- Push when full, OVWR=0: sample dropped, OVERFLOW set.
- Push when full, OVWR=1: oldest word discarded, new word stored, COUNT unchanged, OVERFLOW set.
- Pop when empty: no state change, UNDERFLOW set.
- Push and pop in the same cycle: COUNT unchanged, both succeed; when empty, the push happens and the pop counts as an underflow.
- CLEAR in the same cycle as a push: CLEAR wins and COUNT=0.
- FIFO pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values:
  - data_out=0, output_sample=0, channel_select=0.
  - CTRL=0, DIVIDER=DIV_RESET, NUM_ACTIVE=NUM_SLOTS, SLOT[k]=k.
  - FIFO empty, sticky bits 0, LAST_CHAN=0.
- Slot period = max(DIVIDER,2) cycles.
- output_sample is high for exactly 2 cycles per slot.
- Register write to visible effect: 1 cycle after the strobe rising edge.
- data_out is combinational from registers and FIFO head given addr/enable/data_rd.
- Pushed sample visible in COUNT/DATA: 1 cycle after CAPTURE.

## Test plan
- Reset, then read all registers -> values exactly as listed; output_sample=0 for 100 cycles.
- SLOT[0..2]=100,101,3; NUM_ACTIVE=3; DIVIDER=10; RUN=1; sample bus model returns 0x1000+id -> channel_select sequence 100,101,3,100 at 10-cycle spacing; popped data 0x1064, 0x1065, 0x1003.
- FIFO_DEPTH=4, OVWR=0, six samples, no reads -> COUNT=4, OVERFLOW=1, first four samples retained; repeat with OVWR=1 -> last four samples retained.
- Read DATA on empty FIFO -> data_out=0, UNDERFLOW=1, COUNT=0; then CLEAR -> STATUS=0x1.
- Drop RUN during CAPTURE -> no push, output_sample=0 next cycle; re-arm -> scan restarts at slot 0.
- DIVIDER=0, NUM_ACTIVE=0 -> 2-cycle slot period, single slot repeats; reading DATA with the strobe held 5 cycles pops exactly one word.
